// File: rtl/stall_pkg.sv
// Shared definitions for the pipeline stall controller: state encoding,
// stall cause codes and the performance counter width.
package stall_pkg;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    HAZ = 2'd1,
    MC  = 2'd2,
    MEM = 2'd3
  } stall_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HAZ  = 2'b01;
  localparam logic [1:0] CAUSE_MC   = 2'b10;
  localparam logic [1:0] CAUSE_MEM  = 2'b11;

  localparam int STALL_CNT_W = 16;

  function automatic logic [1:0] cause_of(input stall_state_e st);
    logic [1:0] c;
    case (st)
      RUN:     c = CAUSE_NONE;
      HAZ:     c = CAUSE_HAZ;
      MC:      c = CAUSE_MC;
      MEM:     c = CAUSE_MEM;
      default: c = CAUSE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stall_perf_cnt.sv
// Saturating stalled-cycle counter with synchronous clear; clear beats
// increment, and the count sticks at all-ones instead of wrapping.
module stall_perf_cnt
  import stall_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [STALL_CNT_W-1:0] cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  logic [STALL_CNT_W-1:0] cnt_r;

  // Counter register: async reset, sync clear, saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges load-use, multi-cycle and memory-wait
// stalls into one registered active-low enable for the stage clock gater.
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int RF_AW   = 4,
  parameter int MC_CW   = 5,
  parameter int HAZ_CYC = 1,
  parameter int MEM_TO  = 15
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [RF_AW-1:0]       dcd_rs1,
  input  logic [RF_AW-1:0]       dcd_rs2,
  input  logic [1:0]             dcd_rs_vld,
  input  logic                   exe_ld_vld,
  input  logic [RF_AW-1:0]       exe_ld_rd,
  input  logic                   mc_start,
  input  logic [MC_CW-1:0]       mc_cycles,
  input  logic                   mem_req,
  input  logic                   mem_rdy,
  input  logic                   perf_clr,
  output logic                   stallb_en,
  output logic [1:0]             stall_cause,
  output logic                   mem_to_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // One shared counter serves all three stall kinds, so it must hold the
  // widest of the multi-cycle length and the memory timeout.
  localparam int MEM_W     = $clog2(MEM_TO + 1);
  localparam int CNT_W_RAW = (MC_CW > MEM_W) ? MC_CW : MEM_W;
  localparam int CNT_W     = (CNT_W_RAW < 2) ? 2 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HAZ_LOAD = CNT_W'(HAZ_CYC - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TO - 1);

  stall_state_e     state_r;
  stall_state_e     next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             hazard_s;
  logic             mem_wait_s;
  logic             mc_launch_s;
  logic             timeout_s;
  logic             stall_inc_s;
  logic             stallb_en_r;
  logic [1:0]       stall_cause_r;
  logic             mem_to_err_r;

  assign hazard_s = exe_ld_vld &
                    ((dcd_rs_vld[0] & (dcd_rs1 == exe_ld_rd)) |
                     (dcd_rs_vld[1] & (dcd_rs2 == exe_ld_rd)));

  assign mem_wait_s  = mem_req & ~mem_rdy;
  assign mc_launch_s = mc_start & (mc_cycles != {MC_CW{1'b0}});

  // Next-state and counter decode; memory wins over multi-cycle over hazard.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    timeout_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_wait_s) begin
          next_state_s = MEM;
          next_cnt_s   = CNT_ZERO;
        end else if (mc_launch_s) begin
          next_state_s = MC;
          next_cnt_s   = CNT_W'(mc_cycles) - CNT_ONE;
        end else if (hazard_s) begin
          next_state_s = HAZ;
          next_cnt_s   = HAZ_LOAD;
        end else begin
          next_state_s = RUN;
          next_cnt_s   = CNT_ZERO;
        end
      end
      HAZ: begin
        if (mem_wait_s) begin
          next_state_s = MEM;
          next_cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          next_state_s = RUN;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_state_s = HAZ;
          next_cnt_s   = cnt_r - CNT_ONE;
        end
      end
      // A running mul/div cannot be interrupted; new requests are dropped.
      MC: begin
        if (cnt_r == CNT_ZERO) begin
          next_state_s = RUN;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_state_s = MC;
          next_cnt_s   = cnt_r - CNT_ONE;
        end
      end
      MEM: begin
        if (mem_rdy) begin
          next_state_s = RUN;
          next_cnt_s   = CNT_ZERO;
        end else if (cnt_r == MEM_LAST) begin
          next_state_s = RUN;
          next_cnt_s   = CNT_ZERO;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = MEM;
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        next_state_s = RUN;
        next_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, wait counter and registered outputs derived from next state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      cnt_r         <= CNT_ZERO;
      stallb_en_r   <= 1'b1;
      stall_cause_r <= CAUSE_NONE;
      mem_to_err_r  <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      cnt_r         <= next_cnt_s;
      stallb_en_r   <= (next_state_s == RUN);
      stall_cause_r <= cause_of(next_state_s);
      mem_to_err_r  <= mem_to_err_r | timeout_s;
    end
  end

  assign stall_inc_s = (next_state_s != RUN);

  stall_perf_cnt u_perf_cnt (
    .clk (clk_in),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall_inc_s),
    .cnt (stall_cnt)
  );

  assign stallb_en   = stallb_en_r;
  assign stall_cause = stall_cause_r;
  assign mem_to_err  = mem_to_err_r;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: single-edge vector table, directed
// multi-cycle sequences and random stimulus against a cycle-budget model.
module tb_stall_ctrl;

  localparam int RF_AW   = 4;
  localparam int MC_CW   = 5;
  localparam int HAZ_CYC = 1;
  localparam int MEM_TO  = 15;

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic [RF_AW-1:0] dcd_rs1, dcd_rs2, exe_ld_rd;
  logic [1:0]       dcd_rs_vld;
  logic             exe_ld_vld, mc_start, mem_req, mem_rdy, perf_clr;
  logic [MC_CW-1:0] mc_cycles;
  logic             stallb_en, mem_to_err;
  logic [1:0]       stall_cause;
  logic [15:0]      stall_cnt;

  stall_ctrl #(.RF_AW(RF_AW), .MC_CW(MC_CW), .HAZ_CYC(HAZ_CYC), .MEM_TO(MEM_TO)) dut (
    .clk_in(clk_in), .rst(rst), .dcd_rs1(dcd_rs1), .dcd_rs2(dcd_rs2),
    .dcd_rs_vld(dcd_rs_vld), .exe_ld_vld(exe_ld_vld), .exe_ld_rd(exe_ld_rd),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .mem_req(mem_req), .mem_rdy(mem_rdy),
    .perf_clr(perf_clr), .stallb_en(stallb_en), .stall_cause(stall_cause),
    .mem_to_err(mem_to_err), .stall_cnt(stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the pipeline is waiting for and how long.
  int m_cause;   // 0 run, 1 hazard, 2 multi-cycle, 3 memory
  int m_left;    // stalled cycles still owed to hazard / multi-cycle
  int m_waited;  // stalled cycles spent waiting on memory so far
  int m_cnt;
  bit m_err;

  typedef struct packed {
    logic [3:0] rs1; logic [3:0] rs2; logic [1:0] vld; logic ld; logic [3:0] rd;
    logic mcs; logic [4:0] mcc; logic req; logic rdy;
    logic exp_sb; logic [1:0] exp_cause;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cause = 0; m_left = 0; m_waited = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  function automatic bit model_hazard();
    bit r;
    r = 1'b0;
    if (exe_ld_vld && dcd_rs_vld[0] && dcd_rs1 == exe_ld_rd) r = 1'b1;
    if (exe_ld_vld && dcd_rs_vld[1] && dcd_rs2 == exe_ld_rd) r = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int nc;
    nc = m_cause;
    if (m_cause == 0) begin
      if (mem_req && !mem_rdy) begin nc = 3; m_waited = 1; end
      else if (mc_start && mc_cycles != 5'd0) begin nc = 2; m_left = int'(mc_cycles); end
      else if (model_hazard()) begin nc = 1; m_left = HAZ_CYC; end
    end else if (m_cause == 1) begin
      if (mem_req && !mem_rdy) begin nc = 3; m_waited = 1; end
      else if (m_left <= 1) nc = 0;
      else m_left--;
    end else if (m_cause == 2) begin
      if (m_left <= 1) nc = 0;
      else m_left--;
    end else begin
      if (mem_rdy) nc = 0;
      else if (m_waited >= MEM_TO) begin nc = 0; m_err = 1'b1; end
      else m_waited++;
    end
    m_cause = nc;
    if (perf_clr) m_cnt = 0;
    else if (nc != 0 && m_cnt < 65535) m_cnt++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_stallb"}, 32'(stallb_en), 32'(m_cause == 0));
    chk({tag, "_cause"}, 32'(stall_cause), 32'(m_cause));
    chk({tag, "_err"}, 32'(mem_to_err), 32'(m_err));
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic step(input bit cmp);
    @(posedge clk_in);
    model_edge();
    #1;
    if (cmp) check_model("model");
  endtask

  task automatic expect_out(input string name, input logic sb, input logic [1:0] cs);
    chk({name, "_stallb"}, 32'(stallb_en), 32'(sb));
    chk({name, "_cause"}, 32'(stall_cause), 32'(cs));
  endtask

  task automatic clear_inputs();
    dcd_rs1 = '0; dcd_rs2 = '0; dcd_rs_vld = 2'b00; exe_ld_vld = 1'b0; exe_ld_rd = '0;
    mc_start = 1'b0; mc_cycles = '0; mem_req = 1'b0; mem_rdy = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk_in);
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    int stalled;
    //               rs1   rs2   vld    ld    rd    mcs   mcc    req   rdy   sb    cause
    vt[0]  = '{4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[1]  = '{4'd5, 4'd0, 2'b01, 1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[2]  = '{4'd0, 4'd5, 2'b10, 1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[3]  = '{4'd0, 4'd5, 2'b00, 1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[4]  = '{4'd5, 4'd5, 2'b11, 1'b0, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[5]  = '{4'd0, 4'd0, 2'b11, 1'b1, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01};
    vt[6]  = '{4'd3, 4'd4, 2'b11, 1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[7]  = '{4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 2'b10};
    vt[8]  = '{4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[9]  = '{4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b11};
    vt[10] = '{4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 2'b00};
    vt[11] = '{4'd5, 4'd0, 2'b01, 1'b1, 4'd5, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 2'b11};
    vt[12] = '{4'd5, 4'd0, 2'b01, 1'b1, 4'd5, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 2'b10};

    clear_inputs();
    model_reset();
    rst = 1'b1;
    #1;
    expect_out("por", 1'b1, 2'b00);
    chk("por_cnt", 32'(stall_cnt), 32'h0);
    chk("por_err", 32'(mem_to_err), 32'h0);
    rst = 1'b0;

    // First-edge response from RUN for each vector
    for (int i = 0; i < 13; i++) begin
      hard_reset();
      dcd_rs1 = vt[i].rs1; dcd_rs2 = vt[i].rs2; dcd_rs_vld = vt[i].vld;
      exe_ld_vld = vt[i].ld; exe_ld_rd = vt[i].rd; mc_start = vt[i].mcs;
      mc_cycles = vt[i].mcc; mem_req = vt[i].req; mem_rdy = vt[i].rdy;
      step(1'b1);
      expect_out($sformatf("vec%0d", i), vt[i].exp_sb, vt[i].exp_cause);
    end

    // Load-use hazard: exactly one stalled cycle
    hard_reset();
    exe_ld_vld = 1'b1; exe_ld_rd = 4'd5; dcd_rs2 = 4'd5; dcd_rs_vld = 2'b10;
    step(1'b1);
    expect_out("haz_on", 1'b0, 2'b01);
    chk("haz_cnt", 32'(stall_cnt), 32'd1);
    clear_inputs();
    step(1'b1);
    expect_out("haz_off", 1'b1, 2'b00);
    chk("haz_cnt_hold", 32'(stall_cnt), 32'd1);

    // Multi-cycle op with concurrent hazard: 4 MC cycles, run, then hazard
    hard_reset();
    mc_start = 1'b1; mc_cycles = 5'd4;
    exe_ld_vld = 1'b1; exe_ld_rd = 4'd7; dcd_rs1 = 4'd7; dcd_rs_vld = 2'b01;
    step(1'b1);
    mc_start = 1'b0;
    expect_out("mc_c1", 1'b0, 2'b10);
    for (int i = 2; i <= 4; i++) begin
      step(1'b1);
      expect_out($sformatf("mc_c%0d", i), 1'b0, 2'b10);
    end
    step(1'b1);
    expect_out("mc_end", 1'b1, 2'b00);
    step(1'b1);
    expect_out("mc_haz", 1'b0, 2'b01);
    clear_inputs();
    step(1'b1);
    expect_out("mc_haz_end", 1'b1, 2'b00);
    mc_start = 1'b1; mc_cycles = 5'd0;
    step(1'b1);
    expect_out("mc_zero", 1'b1, 2'b00);
    clear_inputs();

    // Memory wait released by ready after 3 stalled cycles
    hard_reset();
    mem_req = 1'b1; mem_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      expect_out($sformatf("mem_w%0d", i), 1'b0, 2'b11);
    end
    mem_rdy = 1'b1;
    step(1'b1);
    expect_out("mem_rel", 1'b1, 2'b00);
    chk("mem_rel_err", 32'(mem_to_err), 32'h0);
    clear_inputs();

    // Memory timeout: 15 stalled cycles, forced release, sticky error
    hard_reset();
    mem_req = 1'b1; mem_rdy = 1'b0;
    for (int i = 1; i <= MEM_TO; i++) begin
      step(1'b1);
      expect_out($sformatf("to_w%0d", i), 1'b0, 2'b11);
    end
    chk("to_err_pre", 32'(mem_to_err), 32'h0);
    step(1'b1);
    expect_out("to_rel", 1'b1, 2'b00);
    chk("to_err", 32'(mem_to_err), 32'h1);
    step(1'b1);
    expect_out("to_reenter", 1'b0, 2'b11);
    mem_rdy = 1'b1;
    step(1'b1);
    clear_inputs();
    step(1'b1);
    chk("to_err_sticky", 32'(mem_to_err), 32'h1);

    // Async reset in the middle of a multi-cycle stall
    mc_start = 1'b1; mc_cycles = 5'd20;
    step(1'b1);
    mc_start = 1'b0;
    step(1'b1);
    expect_out("rst_pre", 1'b0, 2'b10);
    rst = 1'b1;
    #1;
    expect_out("rst_mid", 1'b1, 2'b00);
    chk("rst_mid_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_mid_err", 32'(mem_to_err), 32'h0);
    model_reset();
    rst = 1'b0;
    step(1'b1);
    expect_out("rst_after", 1'b1, 2'b00);

    // Priority: memory beats MC and hazard; the MC pulse is lost
    hard_reset();
    mem_req = 1'b1; mem_rdy = 1'b0; mc_start = 1'b1; mc_cycles = 5'd2;
    exe_ld_vld = 1'b1; exe_ld_rd = 4'd3; dcd_rs1 = 4'd3; dcd_rs_vld = 2'b01;
    step(1'b1);
    expect_out("pri_mem", 1'b0, 2'b11);
    clear_inputs();
    mem_rdy = 1'b1;
    step(1'b1);
    expect_out("pri_rel", 1'b1, 2'b00);
    step(1'b1);
    expect_out("pri_mc_lost", 1'b1, 2'b00);
    clear_inputs();

    // Hazard stall preempted by a memory wait
    hard_reset();
    exe_ld_vld = 1'b1; exe_ld_rd = 4'd9; dcd_rs2 = 4'd9; dcd_rs_vld = 2'b10;
    step(1'b1);
    expect_out("hp_haz", 1'b0, 2'b01);
    clear_inputs();
    mem_req = 1'b1;
    step(1'b1);
    expect_out("hp_mem", 1'b0, 2'b11);
    clear_inputs();
    mem_rdy = 1'b1;
    step(1'b1);
    clear_inputs();

    // perf_clr during a stall wins over the increment
    hard_reset();
    mem_req = 1'b1; mem_rdy = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("pc_pre", 32'(stall_cnt), 32'd2);
    perf_clr = 1'b1;
    step(1'b1);
    chk("pc_clr", 32'(stall_cnt), 32'd0);
    expect_out("pc_stall", 1'b0, 2'b11);
    perf_clr = 1'b0;
    step(1'b1);
    chk("pc_resume", 32'(stall_cnt), 32'd1);
    clear_inputs();

    // Random stimulus against the model, with occasional async resets
    hard_reset();
    for (int i = 0; i < 2000; i++) begin
      dcd_rs1 = RF_AW'($urandom_range(0, 3));
      dcd_rs2 = RF_AW'($urandom_range(0, 3));
      exe_ld_rd = RF_AW'($urandom_range(0, 3));
      dcd_rs_vld = 2'($urandom_range(0, 3));
      exe_ld_vld = 1'($urandom_range(0, 1));
      mc_start = ($urandom_range(0, 7) == 0);
      mc_cycles = MC_CW'($urandom_range(0, 6));
      mem_req = ($urandom_range(0, 2) == 0);
      mem_rdy = 1'($urandom_range(0, 1));
      perf_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rand_rst");
        rst = 1'b0;
      end
      step(1'b1);
    end
    clear_inputs();

    // Saturation: drive the counter up to FFFE, then 3 more stalled cycles
    hard_reset();
    mc_start = 1'b1; mc_cycles = 5'd31;
    guard = 0;
    while (m_cnt < 65534 && guard < 80000) begin
      step(1'b0);
      guard++;
    end
    chk("sat_pre", 32'(stall_cnt), 32'hFFFE);
    stalled = 0;
    guard = 0;
    while (stalled < 3 && guard < 100) begin
      step(1'b0);
      if (m_cause != 0) stalled++;
      guard++;
    end
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("sat_final", 32'(stall_cnt), 32'hFFFF);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
